morse_tx_keyer: RTL and testbench

Morse transmitter that keys one letter as timed on/off pulses. It takes a letter index (0 = A … 25 = Z), looks up its dot/dash pattern, and drives `key_o` with dot, dash, symbol-gap and character-gap timing. It is the transmit-side counterpart of the Morse input checker, and its output can be looped into `ui_in[1]` of that checker. Default timings assume the 100 Hz system clock.

---
 rtl/morse_pkg.sv | 59 +++++
 rtl/morse_tx_keyer_if.sv | 41 ++++
 rtl/morse_tx_timer.sv | 25 ++
 rtl/morse_tx_keyer.sv | 163 ++++++++++++++++
 tb/tb_morse_tx_keyer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter code table, keyer state encoding and default
// timing constants used by both the transmitter and the receiver.
package morse_pkg;

  localparam int MORSE_NUM_LETTERS = 26;

  localparam int MORSE_DOT_LEN  = 25;
  localparam int MORSE_DASH_LEN = 61;
  localparam int MORSE_SYM_GAP  = 15;
  localparam int MORSE_CHAR_GAP = 50;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_CGAP
  } morse_state_t;

  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } morse_code_t;

  // Dash = 1, dot = 0; the first symbol keyed is pat[len-1].
  function automatic morse_code_t morse_code(input logic [4:0] letter);
    morse_code_t c;
    case (letter)
      5'd0:    c = {3'd2, 4'b0001};  // A .-
      5'd1:    c = {3'd4, 4'b1000};  // B -...
      5'd2:    c = {3'd4, 4'b1010};  // C -.-.
      5'd3:    c = {3'd3, 4'b0100};  // D -..
      5'd4:    c = {3'd1, 4'b0000};  // E .
      5'd5:    c = {3'd4, 4'b0010};  // F ..-.
      5'd6:    c = {3'd3, 4'b0110};  // G --.
      5'd7:    c = {3'd4, 4'b0000};  // H ....
      5'd8:    c = {3'd2, 4'b0000};  // I ..
      5'd9:    c = {3'd4, 4'b0111};  // J .---
      5'd10:   c = {3'd3, 4'b0101};  // K -.-
      5'd11:   c = {3'd4, 4'b0100};  // L .-..
      5'd12:   c = {3'd2, 4'b0011};  // M --
      5'd13:   c = {3'd2, 4'b0010};  // N -.
      5'd14:   c = {3'd3, 4'b0111};  // O ---
      5'd15:   c = {3'd4, 4'b0110};  // P .--.
      5'd16:   c = {3'd4, 4'b1101};  // Q --.-
      5'd17:   c = {3'd3, 4'b0010};  // R .-.
      5'd18:   c = {3'd3, 4'b0000};  // S ...
      5'd19:   c = {3'd1, 4'b0001};  // T -
      5'd20:   c = {3'd3, 4'b0001};  // U ..-
      5'd21:   c = {3'd4, 4'b0001};  // V ...-
      5'd22:   c = {3'd3, 4'b0011};  // W .--
      5'd23:   c = {3'd4, 4'b1001};  // X -..-
      5'd24:   c = {3'd4, 4'b1011};  // Y -.--
      5'd25:   c = {3'd4, 4'b1100};  // Z --..
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/morse_tx_keyer_if.sv
// Request/status bundle of the Morse keyer. abort_i exists only when
// MORSE_TX_ABORT_EN is defined.
interface morse_tx_keyer_if;
  import morse_pkg::*;

  // Handshake: a letter is taken on a rising edge where start_i && ready_o;
  // letter_i is sampled only then. start_i while ready_o is low is ignored
  // (nothing is queued), and done_o/err_o close every accepted request.
  logic         start_i;
  logic [4:0]   letter_i;
  logic         ready_o;
  logic         key_o;
  logic         done_o;
  logic         err_o;
  morse_state_t state;

`ifdef MORSE_TX_ABORT_EN
  logic         abort_i;

  modport master (
    output start_i, letter_i, abort_i,
    input  ready_o, key_o, done_o, err_o, state
  );

  modport slave (
    input  start_i, letter_i, abort_i,
    output ready_o, key_o, done_o, err_o, state
  );
`else
  modport master (
    output start_i, letter_i,
    input  ready_o, key_o, done_o, err_o, state
  );

  modport slave (
    input  start_i, letter_i,
    output ready_o, key_o, done_o, err_o, state
  );
`endif

endinterface

// File: rtl/morse_tx_timer.sv
// 6-bit loadable down-counter that parks at zero; zero_o marks the last cycle
// of the current mark or gap.
module morse_tx_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_val,
  output logic       zero_o
);

  logic [5:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end
  end

  assign zero_o = (cnt == 6'd0);

endmodule

// File: rtl/morse_tx_keyer.sv
// Morse transmitter: keys one letter as timed marks and gaps on key_o.
// Optional abort input enabled by defining MORSE_TX_ABORT_EN.
module morse_tx_keyer
  import morse_pkg::*;
#(
  parameter int DOT_LEN  = MORSE_DOT_LEN,
  parameter int DASH_LEN = MORSE_DASH_LEN,
  parameter int SYM_GAP  = MORSE_SYM_GAP,
  parameter int CHAR_GAP = MORSE_CHAR_GAP
) (
  input logic              clk,
  input logic              rst,
  morse_tx_keyer_if.slave  bus
);

  if (DOT_LEN < 1 || DOT_LEN > 63 || DASH_LEN < 1 || DASH_LEN > 63 ||
      SYM_GAP < 1 || SYM_GAP > 63 || CHAR_GAP < 1 || CHAR_GAP > 63 ||
      DASH_LEN <= DOT_LEN) begin : g_bad_timing
    $error("morse_tx_keyer: timings must be 1..63 and DASH_LEN > DOT_LEN");
  end

  localparam logic [5:0] DOT_M1  = 6'(DOT_LEN - 1);
  localparam logic [5:0] DASH_M1 = 6'(DASH_LEN - 1);
  localparam logic [5:0] SYM_M1  = 6'(SYM_GAP - 1);
  localparam logic [5:0] CGAP_M1 = 6'(CHAR_GAP - 1);

  morse_state_t state_q;
  logic         key_q;
  logic         ready_q;
  logic         done_q;
  logic         err_q;
  logic [3:0]   pat_q;
  logic [1:0]   idx_q;

  morse_code_t  code;
  logic [1:0]   first_idx;
  logic [1:0]   idx_next;
  logic         accept;
  logic         letter_bad;
  logic         abort_hit;
  logic         load;
  logic [5:0]   load_val;
  logic         zero;

  function automatic logic [5:0] mark_m1(input logic dash);
    return dash ? DASH_M1 : DOT_M1;
  endfunction

  // Counter reloads happen on the same edge as the state change they belong to.
  always_comb begin
    code       = morse_code(bus.letter_i);
    first_idx  = 2'(code.len - 3'd1);
    idx_next   = idx_q - 2'd1;
    accept     = bus.start_i && ready_q;
    letter_bad = (bus.letter_i >= 5'(MORSE_NUM_LETTERS));
    abort_hit  = 1'b0;
`ifdef MORSE_TX_ABORT_EN
    abort_hit  = bus.abort_i && (state_q != S_IDLE);
`endif
    load       = 1'b0;
    load_val   = '0;
    if (abort_hit) begin
      load = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && !letter_bad) begin
            load     = 1'b1;
            load_val = mark_m1(code.pat[first_idx]);
          end
        end
        S_MARK: begin
          if (zero) begin
            load     = 1'b1;
            load_val = (idx_q != 2'd0) ? SYM_M1 : CGAP_M1;
          end
        end
        S_SPACE: begin
          if (zero) begin
            load     = 1'b1;
            load_val = mark_m1(pat_q[idx_next]);
          end
        end
        default: ;
      endcase
    end
  end

  morse_tx_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero_o   (zero)
  );

  // idx_q points at the symbol being keyed; zero in MARK means it was the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pat_q   <= '0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_hit) begin
        state_q <= S_IDLE;
        key_q   <= 1'b0;
        ready_q <= 1'b1;
        idx_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              if (letter_bad) begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end else begin
                pat_q   <= code.pat;
                idx_q   <= first_idx;
                key_q   <= 1'b1;
                ready_q <= 1'b0;
                state_q <= S_MARK;
              end
            end
          end
          S_MARK: begin
            if (zero) begin
              key_q   <= 1'b0;
              state_q <= (idx_q != 2'd0) ? S_SPACE : S_CGAP;
            end
          end
          S_SPACE: begin
            if (zero) begin
              idx_q   <= idx_next;
              key_q   <= 1'b1;
              state_q <= S_MARK;
            end
          end
          S_CGAP: begin
            if (zero) begin
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.key_o   = key_q;
  assign bus.ready_o = ready_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_morse_tx_keyer.sv
// Directed bench for morse_tx_keyer: mark lengths go through an expected queue,
// gap lengths and done timing are checked against hand-computed values.
module tb_morse_tx_keyer;
  import morse_pkg::*;

  localparam int DOT    = 25;
  localparam int DASH   = 61;
  localparam int SG     = 15;
  localparam int CG     = 50;
  localparam int BUDGET = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  morse_tx_keyer_if bus();

  morse_tx_keyer #(
    .DOT_LEN  (DOT),
    .DASH_LEN (DASH),
    .SYM_GAP  (SG),
    .CHAR_GAP (CG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  // Accept a letter and follow it to done_o. chained: start_i is already high
  // from the previous letter; hold: leave start_i high after the accept.
  task automatic send_letter(input logic [4:0] l, input int exp_done,
                             input bit chained, input bit hold);
    int hi_run, lo_run, done_cyc;
    bit prev, first;
    if (!chained) begin
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.letter_i = l;
    end
    @(posedge clk);
    #1;
    if (!hold) bus.start_i = 1'b0;
    hi_run = 0; lo_run = 0; done_cyc = 0; prev = 1'b0; first = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        done_cyc = c;
        break;
      end
      if (bus.key_o) begin
        if (!prev) begin
          if (first) check($sformatf("first_rise_l%0d", l), c, 1);
          else       check($sformatf("space_l%0d", l), lo_run, SG);
          first  = 1'b0;
          lo_run = 0;
        end
        hi_run++;
      end else begin
        if (prev) begin
          if (exp_q.size() == 0) check($sformatf("extra_mark_l%0d", l), hi_run, 0);
          else check($sformatf("mark_l%0d", l), hi_run, exp_q.pop_front());
          hi_run = 0;
        end
        lo_run++;
      end
      prev = bus.key_o;
    end
    check($sformatf("done_cycle_l%0d", l), done_cyc, exp_done);
    if (done_cyc != 0) begin
      check($sformatf("cgap_l%0d", l), lo_run, CG);
      check($sformatf("done_ready_l%0d", l), bus.ready_o, 1);
      check($sformatf("done_err_l%0d", l), bus.err_o, 0);
      check($sformatf("done_key_l%0d", l), bus.key_o, 0);
    end
    check($sformatf("marks_left_l%0d", l), exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_invalid(input logic [4:0] l);
    bit saw_key;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.letter_i = l;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(negedge clk);
    check($sformatf("inv_done_l%0d", l), bus.done_o, 1);
    check($sformatf("inv_err_l%0d", l), bus.err_o, 1);
    check($sformatf("inv_key_l%0d", l), bus.key_o, 0);
    check($sformatf("inv_ready_l%0d", l), bus.ready_o, 1);
    @(negedge clk);
    check($sformatf("inv_done_gone_l%0d", l), bus.done_o, 0);
    check($sformatf("inv_err_gone_l%0d", l), bus.err_o, 0);
    saw_key = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.key_o) saw_key = 1'b1;
    end
    check($sformatf("inv_no_key_l%0d", l), saw_key, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.letter_i = '0;
`ifdef MORSE_TX_ABORT_EN
    bus.abort_i  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key", bus.key_o, 0);
    check("rst_ready", bus.ready_o, 1);
    check("rst_done", bus.done_o, 0);
    check("rst_err", bus.err_o, 0);
    rst = 1'b0;

    exp_q.push_back(8'(DOT));
    send_letter(5'd4, 76, 1'b0, 1'b0);                  // E

    exp_q.push_back(8'(DOT)); exp_q.push_back(8'(DASH));
    send_letter(5'd0, 152, 1'b0, 1'b0);                 // A

    exp_q.push_back(8'(DASH)); exp_q.push_back(8'(DASH));
    exp_q.push_back(8'(DOT));  exp_q.push_back(8'(DASH));
    send_letter(5'd16, 304, 1'b0, 1'b0);                // Q

    exp_q.push_back(8'(DASH)); exp_q.push_back(8'(DASH));
    exp_q.push_back(8'(DOT));  exp_q.push_back(8'(DOT));
    send_letter(5'd25, 268, 1'b0, 1'b0);                // Z, last valid index

    send_invalid(5'd27);
    send_invalid(5'd26);

    // start_i held through T: one dash, then a second T taken at the done cycle
    exp_q.push_back(8'(DASH));
    send_letter(5'd19, 112, 1'b0, 1'b1);
    exp_q.push_back(8'(DASH));
    send_letter(5'd19, 112, 1'b1, 1'b0);

    // reset in the middle of B's leading dash
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.letter_i = 5'd1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (30) @(negedge clk);
    check("b_dash_key", bus.key_o, 1);
    check("b_dash_ready", bus.ready_o, 0);
    #2 rst = 1'b1;
    #1;
    check("b_rst_key", bus.key_o, 0);
    check("b_rst_ready", bus.ready_o, 1);
    check("b_rst_state", 32'(bus.state), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    exp_q.push_back(8'(DOT));
    send_letter(5'd4, 76, 1'b0, 1'b0);                  // E after reset

`ifdef MORSE_TX_ABORT_EN
    begin
      bit saw_key, saw_done;
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.letter_i = 5'd0;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_in_space", 32'(bus.state), 32'(S_SPACE));
      bus.abort_i = 1'b1;
      @(posedge clk);
      #1 bus.abort_i = 1'b0;
      check("abort_key", bus.key_o, 0);
      check("abort_ready", bus.ready_o, 1);
      check("abort_done", bus.done_o, 0);
      saw_key = 1'b0; saw_done = 1'b0;
      for (int i = 0; i < 120; i++) begin
        @(negedge clk);
        if (bus.key_o)  saw_key  = 1'b1;
        if (bus.done_o) saw_done = 1'b1;
      end
      check("abort_no_key", saw_key, 0);
      check("abort_no_done", saw_done, 0);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
